rv_iopmp_dl_se_scan_ctrl: RTL and testbench
===========================================

// Module: rv_iopmp_dl_se_scan_ctrl
// PURPOSE
// Sequencer for the source-enforcement decision path when NUMBER_ENTRIES > NUMBER_ENTRY_ANALYZERS.
// Accepts one transaction at a time and steps entry_offset_o through entry windows of NUMBER_ENTRY_ANALYZERS.
// Stops at the first window with a match; the lowest entry index has priority.
// Returns allow/error to the IOPMP response path over a valid/ready handshake.
// PARAMETERS
// NUMBER_ENTRIES          32  total IOPMP entries; multiple of NUMBER_ENTRY_ANALYZERS, <= 512
// NUMBER_ENTRY_ANALYZERS   8  entries evaluated per cycle (window size)
// ID_WIDTH                 8  transaction tag width, returned unchanged
// PORTS
// clk_i              in   1    clock
// rst_i              in   1    asynchronous reset, active-high
// enable_i           in   1    IOPMP enable, sampled at request accept
// cfg_update_i       in   1    entry table written this cycle; restarts an in-flight scan
// req_valid_i        in   1    transaction request valid
// req_ready_o        out  1    controller idle, can accept a request
// req_id_i           in   ID_WIDTH  transaction tag
// req_access_i       in   rv_iopmp_pkg::access_t  access type
// entry_offset_o     out  9    base index of the window currently presented to the analyzers
// win_match_i        in   NUMBER_ENTRY_ANALYZERS  per-entry match, combinational on entry_offset_o
// win_allow_i        in   NUMBER_ENTRY_ANALYZERS  per-entry permission, combinational on entry_offset_o
// rsp_valid_o        out  1    decision valid
// rsp_ready_i        in   1    consumer accepts decision
// rsp_id_o           out  ID_WIDTH  tag of the decided transaction
// rsp_allow_o        out  1    transaction allowed
// rsp_err_o          out  1    error to record
// rsp_err_type_o     out  3    error type code
// rsp_err_index_o    out  16   violating entry index
// BEHAVIOUR
// - Reset: state IDLE; offset, id, access and all rsp_* registers cleared to 0. rsp_valid_o=0; req_ready_o=1 while in IDLE.
// - FSM states IDLE, SCAN, RESP. req_ready_o = (state==IDLE); rsp_valid_o = (state==RESP).
// - IDLE: on req_valid_i&req_ready_o, capture id/access and clear offset to 0.
//   - enable_i=1: go to SCAN.
//   - enable_i=0: go to RESP with allow=0, err=0, type=0, index=0.
// - SCAN, each cycle at the current offset:
//   - cfg_update_i=1: set offset to 0 and stay in SCAN. Same-cycle window results are discarded; this has priority over match and no-hit.
//   - else if |win_match_i: j = lowest set bit of win_match_i.
//     - win_allow_i[j]=1: allow=1, err=0.
//     - else: allow=0, err=1, index=offset+j; type READ=3'h1, WRITE=3'h2, EXECUTION=3'h3, any other access=3'h7.
//     - Go to RESP.
//   - else if offset == NUMBER_ENTRIES-NUMBER_ENTRY_ANALYZERS: no hit; allow=0, err=1, type=3'h5, index=0; go to RESP.
//   - else: offset += NUMBER_ENTRY_ANALYZERS.
// - RESP: rsp_* held stable until rsp_ready_i. On the handshake, go to IDLE; the next request is accepted no earlier than the following cycle.
//   cfg_update_i is ignored in RESP.
// - Latency: a match in window k (0-based) gives rsp_valid_o k+2 cycles after the accept edge. Full no-hit scan = NUMBER_ENTRIES/NUMBER_ENTRY_ANALYZERS+1 cycles.
// - entry_offset_o = offset register; holds its last value in RESP and IDLE. Index arithmetic is zero-extended to 16 bits.
// - Asynchronous reset mid-SCAN or mid-RESP drops the transaction; no response is issued.
// STRUCTURE
// - rv_iopmp_pkg gains dl_scan_state_e {IDLE,SCAN,RESP} and error-code constants ERR_READ=1, ERR_WRITE=2, ERR_EXEC=3, ERR_NOT_HIT=5, ERR_UNKNOWN=7.
// - Sub-module rv_iopmp_dl_prio_enc: lowest-first-one encoder, NUMBER_ENTRY_ANALYZERS wide; outputs hit flag and index.
// - Elaboration assertion: NUMBER_ENTRIES % NUMBER_ENTRY_ANALYZERS == 0.
// TESTING (NUMBER_ENTRIES=32, NUMBER_ENTRY_ANALYZERS=8)
// - Match at entry 2 in window 0, allow=1, READ -> rsp_valid_o at accept+2, allow=1, err=0, offsets seen {0}.
// - Match only at entry 19, allow=0, WRITE -> offsets seen 0,8,16; rsp allow=0, err=1, type=2, index=19, at accept+4.
// - Matches at entries 9 (deny) and 12 (allow), EXECUTION -> index=9, type=3; entry 12 ignored.
// - No match anywhere -> offsets 0,8,16,24; type=5, err=1, index=0 at accept+5; enable_i=0 -> allow=0, err=0 at accept+1.
// - cfg_update_i pulsed in the same cycle as a window-1 match -> offset returns to 0, scan restarts, response reflects the rescan.
// - rsp_ready_i held low 5 cycles -> rsp_* stable and req_ready_o=0 throughout; rst_i asserted mid-SCAN -> IDLE, rsp_valid_o=0, offset=0.

Source files
------------

// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access encoding, decision-path scan states and error codes.
package rv_iopmp_pkg;

  typedef enum logic [1:0] {
    ACCESS_NONE      = 2'd0,
    ACCESS_READ      = 2'd1,
    ACCESS_WRITE     = 2'd2,
    ACCESS_EXECUTION = 2'd3
  } access_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } dl_scan_state_e;

  localparam logic [2:0] ERR_NONE    = 3'h0;
  localparam logic [2:0] ERR_READ    = 3'h1;
  localparam logic [2:0] ERR_WRITE   = 3'h2;
  localparam logic [2:0] ERR_EXEC    = 3'h3;
  localparam logic [2:0] ERR_NOT_HIT = 3'h5;
  localparam logic [2:0] ERR_UNKNOWN = 3'h7;

  function automatic logic [2:0] access_err_type(input access_t acc);
    logic [2:0] code;
    case (acc)
      ACCESS_READ:      code = ERR_READ;
      ACCESS_WRITE:     code = ERR_WRITE;
      ACCESS_EXECUTION: code = ERR_EXEC;
      default:          code = ERR_UNKNOWN;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rv_iopmp_dl_se_scan_ctrl_if.sv
// Request/window/response bundle between the scan controller (slave) and its environment (master).
interface rv_iopmp_dl_se_scan_ctrl_if #(
  parameter int NUMBER_ENTRY_ANALYZERS = 8,
  parameter int ID_WIDTH               = 8
);
  import rv_iopmp_pkg::*;

  logic                              enable_i;
  logic                              cfg_update_i;
  logic                              req_valid_i;
  logic                              req_ready_o;
  logic [ID_WIDTH-1:0]               req_id_i;
  access_t                           req_access_i;
  logic [8:0]                        entry_offset_o;
  logic [NUMBER_ENTRY_ANALYZERS-1:0] win_match_i;
  logic [NUMBER_ENTRY_ANALYZERS-1:0] win_allow_i;
  logic                              rsp_valid_o;
  logic                              rsp_ready_i;
  logic [ID_WIDTH-1:0]               rsp_id_o;
  logic                              rsp_allow_o;
  logic                              rsp_err_o;
  logic [2:0]                        rsp_err_type_o;
  logic [15:0]                       rsp_err_index_o;

  modport slave (
    input  enable_i, cfg_update_i, req_valid_i, req_id_i, req_access_i,
           win_match_i, win_allow_i, rsp_ready_i,
    output req_ready_o, entry_offset_o, rsp_valid_o, rsp_id_o,
           rsp_allow_o, rsp_err_o, rsp_err_type_o, rsp_err_index_o
  );

  modport master (
    output enable_i, cfg_update_i, req_valid_i, req_id_i, req_access_i,
           win_match_i, win_allow_i, rsp_ready_i,
    input  req_ready_o, entry_offset_o, rsp_valid_o, rsp_id_o,
           rsp_allow_o, rsp_err_o, rsp_err_type_o, rsp_err_index_o
  );

endinterface

// File: rtl/rv_iopmp_dl_prio_enc.sv
// Lowest-first-one encoder: purely combinational, zero latency, no flow control.
module rv_iopmp_dl_prio_enc #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rv_iopmp_dl_se_scan_ctrl.sv
// Source-enforcement scan sequencer: walks entry windows until the first match, then returns allow/error.
// Latency: window k hit gives rsp_valid k+2 cycles after accept; rsp_* held until rsp_ready_i.
module rv_iopmp_dl_se_scan_ctrl
  import rv_iopmp_pkg::*;
#(
  parameter int NUMBER_ENTRIES         = 32,
  parameter int NUMBER_ENTRY_ANALYZERS = 8,
  parameter int ID_WIDTH               = 8
) (
  input logic                        clk_i,
  input logic                        rst_i,
  rv_iopmp_dl_se_scan_ctrl_if.slave  bus
);

  localparam int         IDX_W    = (NUMBER_ENTRY_ANALYZERS > 1) ? $clog2(NUMBER_ENTRY_ANALYZERS) : 1;
  localparam logic [8:0] STEP     = 9'(NUMBER_ENTRY_ANALYZERS);
  localparam logic [8:0] LAST_OFF = 9'(NUMBER_ENTRIES - NUMBER_ENTRY_ANALYZERS);

  if (NUMBER_ENTRIES % NUMBER_ENTRY_ANALYZERS != 0) begin : g_bad_window
    $error("NUMBER_ENTRIES must be a multiple of NUMBER_ENTRY_ANALYZERS");
  end
  if (NUMBER_ENTRIES > 512) begin : g_bad_entries
    $error("NUMBER_ENTRIES must not exceed 512");
  end

  dl_scan_state_e      state_q, state_d;
  logic [8:0]          offset_q, offset_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  access_t             access_q, access_d;
  logic                allow_q, allow_d;
  logic                err_q, err_d;
  logic [2:0]          err_type_q, err_type_d;
  logic [15:0]         err_index_q, err_index_d;

  logic                hit;
  logic [IDX_W-1:0]    hit_idx;

  rv_iopmp_dl_prio_enc #(
    .WIDTH (NUMBER_ENTRY_ANALYZERS)
  ) u_prio_enc (
    .req (bus.win_match_i),
    .hit (hit),
    .idx (hit_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      offset_q    <= '0;
      id_q        <= '0;
      access_q    <= ACCESS_NONE;
      allow_q     <= 1'b0;
      err_q       <= 1'b0;
      err_type_q  <= ERR_NONE;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      id_q        <= id_d;
      access_q    <= access_d;
      allow_q     <= allow_d;
      err_q       <= err_d;
      err_type_q  <= err_type_d;
      err_index_q <= err_index_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    id_d        = id_q;
    access_d    = access_q;
    allow_d     = allow_q;
    err_d       = err_q;
    err_type_d  = err_type_q;
    err_index_d = err_index_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          id_d     = bus.req_id_i;
          access_d = bus.req_access_i;
          offset_d = '0;
          if (bus.enable_i) begin
            state_d = SCAN;
          end else begin
            state_d     = RESP;
            allow_d     = 1'b0;
            err_d       = 1'b0;
            err_type_d  = ERR_NONE;
            err_index_d = '0;
          end
        end
      end

      SCAN: begin
        // A table rewrite invalidates this window's results, so rescan from the start.
        if (bus.cfg_update_i) begin
          offset_d = '0;
        end else if (hit) begin
          state_d = RESP;
          if (bus.win_allow_i[hit_idx]) begin
            allow_d = 1'b1;
            err_d   = 1'b0;
          end else begin
            allow_d     = 1'b0;
            err_d       = 1'b1;
            err_type_d  = access_err_type(access_q);
            err_index_d = 16'(offset_q) + 16'(hit_idx);
          end
        end else if (offset_q == LAST_OFF) begin
          state_d     = RESP;
          allow_d     = 1'b0;
          err_d       = 1'b1;
          err_type_d  = ERR_NOT_HIT;
          err_index_d = '0;
        end else begin
          offset_d = offset_q + STEP;
        end
      end

      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o     = (state_q == IDLE);
  assign bus.rsp_valid_o     = (state_q == RESP);
  assign bus.entry_offset_o  = offset_q;
  assign bus.rsp_id_o        = id_q;
  assign bus.rsp_allow_o     = allow_q;
  assign bus.rsp_err_o       = err_q;
  assign bus.rsp_err_type_o  = err_type_q;
  assign bus.rsp_err_index_o = err_index_q;

endmodule

// File: tb/tb_rv_iopmp_dl_se_scan_ctrl.sv
// Scoreboard bench: driver predicts each decision from a flat entry table, monitor checks responses and offsets.
module tb_rv_iopmp_dl_se_scan_ctrl;
  import rv_iopmp_pkg::*;

  localparam int NE = 32;
  localparam int NA = 8;
  localparam int IW = 8;
  localparam int NWIN = NE / NA;

  typedef struct {
    logic [IW-1:0] id;
    logic          allow;
    logic          err;
    logic [2:0]    typ;
    logic [15:0]   idx;
    int            lat;
    int            k;
    int            rst_r;
    bit            chk_info;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_iopmp_dl_se_scan_ctrl_if #(.NUMBER_ENTRY_ANALYZERS(NA), .ID_WIDTH(IW)) ifc ();

  rv_iopmp_dl_se_scan_ctrl #(
    .NUMBER_ENTRIES         (NE),
    .NUMBER_ENTRY_ANALYZERS (NA),
    .ID_WIDTH               (IW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  logic [NE-1:0] tbl_m = '0;
  logic [NE-1:0] tbl_a = '0;
  assign ifc.win_match_i = tbl_m[ifc.entry_offset_o +: NA];
  assign ifc.win_allow_i = tbl_a[ifc.entry_offset_o +: NA];

  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0;
  int   drv_timeouts = 0;
  int   hold_until = 0;
  int   pcnt = 0;
  bit   done = 1'b0;
  logic [IW-1:0] id_ctr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference decision: first matching entry over the whole table decides.
  function automatic exp_t predict(input logic [NE-1:0] m, input logic [NE-1:0] a,
                                   input access_t acc, input bit en, input logic [IW-1:0] id);
    exp_t e;
    bit   found = 1'b0;
    e.id = id; e.allow = 1'b0; e.err = 1'b1; e.typ = 3'd5; e.idx = 16'd0;
    e.k = NWIN - 1; e.rst_r = -1; e.chk_info = 1'b1;
    for (int i = 0; i < NE; i++) begin
      if (!found && m[i]) begin
        found = 1'b1;
        e.k = i / NA;
        if (a[i]) begin
          e.allow = 1'b1; e.err = 1'b0; e.chk_info = 1'b0;
        end else begin
          e.idx = 16'(i);
          case (acc)
            ACCESS_READ:      e.typ = 3'd1;
            ACCESS_WRITE:     e.typ = 3'd2;
            ACCESS_EXECUTION: e.typ = 3'd3;
            default:          e.typ = 3'd7;
          endcase
        end
      end
    end
    e.lat = e.k + 2;
    if (!en) begin
      e.allow = 1'b0; e.err = 1'b0; e.typ = 3'd0; e.idx = 16'd0;
      e.lat = 1; e.k = 0; e.chk_info = 1'b1;
    end
    return e;
  endfunction

  function automatic int exp_off(input exp_t e, input int i);
    int j;
    j = i;
    if (e.rst_r >= 0) j = (i <= e.rst_r) ? i : i - (e.rst_r + 1);
    return j * NA;
  endfunction

  task automatic issue(input logic [NE-1:0] m, input logic [NE-1:0] a, input access_t acc,
                       input bit en, input int r_in, input logic [NE-1:0] nm,
                       input logic [NE-1:0] na, input bit push);
    bit   ok = 1'b0;
    exp_t e, e2;
    int   r;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(posedge clk); #1;
      ok = ifc.req_ready_o;
    end
    if (!ok) begin
      drv_timeouts++;
      return;
    end
    tbl_m = m; tbl_a = a;
    id_ctr = id_ctr + 8'd1;
    e = predict(m, a, acc, en, id_ctr);
    r = r_in;
    if (!(en && r >= 0 && r <= e.k)) r = -1;
    if (r >= 0) begin
      e2 = predict(nm, na, acc, en, id_ctr);
      e2.lat = e2.lat + r + 1;
      e2.rst_r = r;
      e = e2;
    end
    if (push) exp_q.push_back(e);
    ifc.req_valid_i  = 1'b1;
    ifc.req_id_i     = id_ctr;
    ifc.req_access_i = acc;
    ifc.enable_i     = en;
    @(posedge clk); #1;
    ifc.req_valid_i  = 1'b0;
    ifc.enable_i     = 1'($urandom);
    ifc.req_access_i = access_t'($urandom_range(0, 3));
    if (r >= 0) begin
      repeat (r) begin @(posedge clk); #1; end
      ifc.cfg_update_i = 1'b1;
      tbl_m = nm; tbl_a = na;
      @(posedge clk); #1;
      ifc.cfg_update_i = 1'b0;
    end
  endtask

  // Consumer backpressure: random ready, forced low while a hold window is requested.
  initial begin
    ifc.rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      pcnt++;
      if (pcnt < hold_until) ifc.rsp_ready_i = 1'b0;
      else                   ifc.rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: all comparisons happen here, on the falling edge.
  initial begin
    int   ncnt = 0, accept_t = 0, scan_i = 0, seen_to = 0;
    bit   in_scan = 1'b0, in_rsp = 1'b0;
    exp_t cur;
    logic [28:0] snap = '0, now;
    forever begin
      @(negedge clk);
      ncnt++;
      if (drv_timeouts != seen_to) begin
        chk("req_ready_timeout", 64'(seen_to), 64'(drv_timeouts));
        seen_to = drv_timeouts;
      end
      if (done) begin
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
      now = {ifc.rsp_id_o, ifc.rsp_allow_o, ifc.rsp_err_o, ifc.rsp_err_type_o, ifc.rsp_err_index_o};
      if (rst) begin
        in_scan = 1'b0; in_rsp = 1'b0;
        chk("reset_req_ready", 64'(ifc.req_ready_o), 64'd1);
        chk("reset_rsp_valid", 64'(ifc.rsp_valid_o), 64'd0);
        chk("reset_offset", 64'(ifc.entry_offset_o), 64'd0);
        chk("reset_rsp_fields", 64'(now), 64'd0);
      end else begin
        if (ifc.rsp_valid_o) begin
          in_scan = 1'b0;
          chk("req_ready_in_resp", 64'(ifc.req_ready_o), 64'd0);
          if (!in_rsp) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_rsp", 64'(ifc.rsp_valid_o), 64'd0);
            end else begin
              cur = exp_q.pop_front();
              chk("rsp_id", 64'(ifc.rsp_id_o), 64'(cur.id));
              chk("rsp_allow", 64'(ifc.rsp_allow_o), 64'(cur.allow));
              chk("rsp_err", 64'(ifc.rsp_err_o), 64'(cur.err));
              if (cur.chk_info) begin
                chk("rsp_err_type", 64'(ifc.rsp_err_type_o), 64'(cur.typ));
                chk("rsp_err_index", 64'(ifc.rsp_err_index_o), 64'(cur.idx));
              end
              chk("rsp_latency", 64'(ncnt - accept_t), 64'(cur.lat));
            end
            in_rsp = 1'b1;
            snap = now;
          end else begin
            chk("rsp_stable", 64'(now), 64'(snap));
          end
          if (ifc.rsp_ready_i) in_rsp = 1'b0;
        end else if (in_scan) begin
          if (exp_q.size() > 0)
            chk("scan_offset", 64'(ifc.entry_offset_o), 64'(exp_off(exp_q[0], scan_i)));
          scan_i++;
        end
        if (ifc.req_valid_i && ifc.req_ready_o) begin
          in_scan = 1'b1; scan_i = 0; accept_t = ncnt;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NE-1:0] m, a, nm, na;
    ifc.req_valid_i  = 1'b0;
    ifc.cfg_update_i = 1'b0;
    ifc.enable_i     = 1'b1;
    ifc.req_id_i     = '0;
    ifc.req_access_i = ACCESS_READ;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(32'h1 << 2, 32'h1 << 2, ACCESS_READ, 1'b1, -1, '0, '0, 1'b1);
    issue(32'h1 << 19, '0, ACCESS_WRITE, 1'b1, -1, '0, '0, 1'b1);
    issue((32'h1 << 9) | (32'h1 << 12), 32'h1 << 12, ACCESS_EXECUTION, 1'b1, -1, '0, '0, 1'b1);
    issue('0, '1, ACCESS_READ, 1'b1, -1, '0, '0, 1'b1);
    issue(32'h1 << 30, '0, ACCESS_NONE, 1'b1, -1, '0, '0, 1'b1);
    issue(32'h1 << 5, '0, ACCESS_WRITE, 1'b0, -1, '0, '0, 1'b1);
    issue(32'h1 << 10, 32'h1 << 10, ACCESS_READ, 1'b1, 1, 32'h1 << 27, '0, 1'b1);
    hold_until = pcnt + 10;
    issue(32'h1 << 0, '0, ACCESS_EXECUTION, 1'b1, -1, '0, '0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      m  = $urandom & $urandom & $urandom;
      a  = $urandom;
      nm = $urandom & $urandom & $urandom;
      na = $urandom;
      issue(m, a, access_t'($urandom_range(0, 3)), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1, nm, na, 1'b1);
    end

    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
    issue('0, '0, ACCESS_READ, 1'b1, -1, '0, '0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue(32'h1 << 13, '0, ACCESS_READ, 1'b1, -1, '0, '0, 1'b1);

    for (int t = 0; t < 500; t++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !ifc.rsp_valid_o) break;
    end
    done = 1'b1;
  end

endmodule
